// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// presents it to the decoder, counts retired words, and halts on a debug event.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  debug,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {StFetch, StIssue, StHalt} state_e;

  state_e      state_q, state_d;
  // Low during reset and until the first clock edge after release; gates the first request.
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic [1:0]  cause_q, cause_d;

  logic fetch_done;
  logic accept;

  assign fetch_done = run_q && (state_q == StFetch) && imem_ack;
  assign accept     = (state_q == StIssue) && instr_ready;

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: if (fetch_done) state_d = StIssue;
      StIssue: if (instr_ready) state_d = (debug == 2'b00) ? StFetch : StHalt;
      StHalt:  if (resume) state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Datapath next values: capture on ack, advance pc and count on accept.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    if (fetch_done) begin
      instr_d = imem_rdata;
    end
    if (accept) begin
      pc_d      = pc_q + 32'd4;
      retired_d = retired_q + 32'd1;
      // Code 11 is undefined and is treated as a failure.
      if (debug != 2'b00) begin
        cause_d = (debug == 2'b01) ? 2'b01 : 2'b10;
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    imem_req    = run_q && (state_q == StFetch);
    imem_addr   = {pc_q[31:2], 2'b00};
    instr_valid = (state_q == StIssue);
    halted      = (state_q == StHalt);
    instruction = instr_q;
    pc          = pc_q;
    halt_cause  = cause_q;
    retired     = retired_q;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first instruction address after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 The block SHALL have port imem_addr  output  32  read address, word-aligned.
REQ-006 The block SHALL have port imem_ack  input  1  memory response valid; imem_rdata valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 The block SHALL have port instruction  output  32  registered instruction to the decoder.
REQ-009 The block SHALL have port instr_valid  output  1  instruction holds a valid word.
REQ-010 The block SHALL have port instr_ready  input  1  downstream accepts instruction this cycle.
REQ-011 The block SHALL have port debug  input  2  decoder status for current instruction: 00 OK, 01 BREAK, 10 FAIL.
REQ-012 The block SHALL have port resume  input  1  leave HALT and continue fetching.
REQ-013 The block SHALL have port pc  output  32  address of the word in FETCH or ISSUE.
REQ-014 The block SHALL have port halted  output  1  high in HALT state.
REQ-015 The block SHALL have port halt_cause  output  2  debug code latched on entering HALT.
REQ-016 The block SHALL have port retired  output  32  count of accepted instructions.

Function
REQ-017 The FSM SHALL have states FETCH, ISSUE, HALT; all outputs are decoded from registered state only.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack.
REQ-019 On imem_ack in FETCH, instruction SHALL load imem_rdata and the FSM SHALL enter ISSUE next cycle; minimum FETCH-to-ISSUE latency is 1 cycle.
REQ-020 imem_ack in ISSUE or HALT SHALL be ignored; instruction and pc unchanged.
REQ-021 In ISSUE, instr_valid SHALL be 1 and instruction SHALL be held stable until instr_ready.
REQ-022 Accept = ISSUE and instr_ready; on accept, retired SHALL increment by 1, wrapping 32'hFFFF_FFFF -> 0.
REQ-023 On accept with debug=00, pc SHALL become pc+4 (modulo 2^32, 32'hFFFF_FFFC -> 0) and the FSM SHALL enter FETCH.
REQ-024 On accept with debug=01 or 10, pc SHALL become pc+4, halt_cause SHALL latch debug, and the FSM SHALL enter HALT.
REQ-025 On accept with debug=11, the block SHALL treat it as FAIL (halt_cause=10).
REQ-026 In HALT, imem_req=0, instr_valid=0, halted=1; resume SHALL move to FETCH next cycle, halt_cause retained until the next HALT entry.
REQ-027 resume outside HALT SHALL have no effect.
REQ-028 debug SHALL be sampled only at accept; its value in other cycles is don't-care.
REQ-029 imem_addr[1:0] SHALL always be 00.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state FETCH, pc=RESET_PC, instruction=0, retired=0, halt_cause=00.
REQ-031 During reset, imem_req=0, instr_valid=0, halted=0; FETCH requests begin the first rising clk edge after rst_n deasserts.
REQ-032 Reset asserted mid-FETCH or mid-ISSUE SHALL drop imem_req and instr_valid immediately, without waiting for clk; an outstanding imem_ack is discarded.

Verification
REQ-033 Reset release, imem_ack same cycle as req with rdata=32'h0000_0033, instr_ready=1, debug=00 -> imem_addr 0,4,8 on successive fetches, retired=1 after first accept.
REQ-034 imem_ack delayed 3 cycles -> imem_req and imem_addr=0 held 4 cycles, instr_valid rises the cycle after ack.
REQ-035 instr_ready low 5 cycles in ISSUE -> instruction and instr_valid stable, pc and retired unchanged, no new imem_req.
REQ-036 debug=01 at accept of word at pc=8 -> halted=1, halt_cause=01, pc=12, imem_req=0; resume pulse -> next fetch at imem_addr=12.
REQ-037 RESET_PC=32'hFFFF_FFFC, one accepted OK instruction -> next imem_addr=0; retired preloaded via 2^32 accepts not required, check wrap by forcing.
REQ-038 rst_n pulsed low between clk edges during FETCH with imem_ack pending -> imem_req falls asynchronously, pc=RESET_PC, late ack ignored.
